// File: rtl/femto_pkg.sv
// Shared definitions for the femto instruction sequencer: opcodes, FSM states
// and the instruction-word width derivation.
package femto_pkg;

  localparam int unsigned OP_LDI = 0;
  localparam int unsigned OP_ADD = 1;
  localparam int unsigned OP_SUB = 2;
  localparam int unsigned OP_AND = 3;
  localparam int unsigned OP_OR  = 4;
  localparam int unsigned OP_XOR = 5;
  localparam int unsigned OP_MOV = 6;
  localparam int unsigned OP_OUT = 7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_IMM,
    S_READ,
    S_EXEC,
    S_WB
  } state_e;

  // Instruction word: op in the top OPSIZE bits, then rd, then rs.
  function automatic int unsigned iw_of(input int unsigned opsize,
                                        input int unsigned numrf);
    return opsize + 2 * numrf;
  endfunction

endpackage

// File: rtl/femto_ififo.sv
// Instruction FIFO: synchronous, count-based full/empty, no write-to-read bypass.
module femto_ififo #(
  parameter int unsigned W      = 7,
  parameter int unsigned QDEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int unsigned DEPTH = 2 ** QDEPTH;

  logic [W-1:0]      mem_q [DEPTH];
  logic [QDEPTH-1:0] wr_q, wr_d;
  logic [QDEPTH-1:0] rd_q, rd_d;
  logic [QDEPTH:0]   cnt_q, cnt_d;
  logic              push_ok, pop_ok;

  assign full    = (cnt_q == (QDEPTH + 1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign head    = mem_q[rd_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Next pointer and occupancy values.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_ok) wr_d = wr_q + QDEPTH'(1);
    if (pop_ok)  rd_d = rd_q + QDEPTH'(1);
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + (QDEPTH + 1)'(1);
      2'b01:   cnt_d = cnt_q - (QDEPTH + 1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage array; contents are don't-care while the count says empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/femto_seq.sv
// femto instruction sequencer: buffers instruction words and steps the
// datapath through IDLE/IMM/READ/EXEC/WB, with all controls registered.
module femto_seq
  import femto_pkg::*;
#(
  parameter  int unsigned OPSIZE = 3,
  parameter  int unsigned NUMRF  = 2,
  parameter  int unsigned SIZE   = 4,
  parameter  int unsigned QDEPTH = 2,
  localparam int unsigned IW     = iw_of(OPSIZE, NUMRF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              in_valid,
  input  logic [IW-1:0]     in_data,
  output logic              in_ready,
  output logic [NUMRF-1:0]  rf_raddr_a,
  output logic [NUMRF-1:0]  rf_raddr_b,
  output logic [OPSIZE-1:0] alu_op,
  output logic              alu_en,
  output logic              rf_we,
  output logic [NUMRF-1:0]  rf_waddr,
  output logic              wb_sel,
  output logic [SIZE-1:0]   imm,
  output logic              out_we,
  output logic              busy,
  output logic [7:0]        retired
);

  state_e             state_q, state_d;
  logic [IW-1:0]      ir_q, ir_d;
  logic [SIZE-1:0]    imm_q, imm_d;
  logic [7:0]         retired_q, retired_d;
  logic               alu_en_q, alu_en_d;
  logic               rf_we_q, rf_we_d;
  logic               out_we_q, out_we_d;
  logic               wb_sel_q, wb_sel_d;

  logic               fifo_full, fifo_empty, fifo_pop;
  logic [IW-1:0]      fifo_head;
  logic [OPSIZE-1:0]  head_op, ir_op;

  femto_ififo #(
    .W      (IW),
    .QDEPTH (QDEPTH)
  ) u_ififo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid && !fifo_full),
    .pop   (fifo_pop),
    .din   (in_data),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head_op    = fifo_head[IW-1 -: OPSIZE];
  assign ir_op      = ir_q[IW-1 -: OPSIZE];

  assign in_ready   = !fifo_full;
  assign rf_raddr_a = ir_q[2*NUMRF-1 -: NUMRF];
  assign rf_raddr_b = ir_q[NUMRF-1:0];
  assign rf_waddr   = ir_q[2*NUMRF-1 -: NUMRF];
  assign alu_op     = ir_op;
  assign alu_en     = alu_en_q;
  assign rf_we      = rf_we_q;
  assign out_we     = out_we_q;
  assign wb_sel     = wb_sel_q;
  assign imm        = imm_q;
  assign retired    = retired_q;
  assign busy       = (state_q != S_IDLE);

  // Next-state logic; each pulse is computed one state early so it is
  // registered and lands exactly in the state that owns it.
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    imm_d     = imm_q;
    retired_d = retired_q;
    wb_sel_d  = wb_sel_q;
    alu_en_d  = 1'b0;
    rf_we_d   = 1'b0;
    out_we_d  = 1'b0;
    fifo_pop  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run && !fifo_empty) begin
          fifo_pop = 1'b1;
          ir_d     = fifo_head;
          wb_sel_d = (head_op == OPSIZE'(OP_LDI));
          state_d  = (head_op == OPSIZE'(OP_LDI)) ? S_IMM : S_READ;
        end
      end
      S_IMM: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          imm_d    = fifo_head[SIZE-1:0];
          rf_we_d  = 1'b1;
          state_d  = S_WB;
        end
      end
      S_READ: begin
        alu_en_d = 1'b1;
        state_d  = S_EXEC;
      end
      S_EXEC: begin
        if (ir_op == OPSIZE'(OP_OUT)) out_we_d = 1'b1;
        else                          rf_we_d  = 1'b1;
        state_d = S_WB;
      end
      S_WB: begin
        retired_d = retired_q + 8'd1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state, instruction/immediate registers, counter and registered controls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ir_q      <= '0;
      imm_q     <= '0;
      retired_q <= '0;
      alu_en_q  <= 1'b0;
      rf_we_q   <= 1'b0;
      out_we_q  <= 1'b0;
      wb_sel_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      imm_q     <= imm_d;
      retired_q <= retired_d;
      alu_en_q  <= alu_en_d;
      rf_we_q   <= rf_we_d;
      out_we_q  <= out_we_d;
      wb_sel_q  <= wb_sel_d;
    end
  end

endmodule

// File: tb/tb_femto_seq.sv
// Scoreboard bench for femto_seq: stimulus pushes expected ALU and write-back
// events into queues, a negedge monitor pops and compares them.
module tb_femto_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic       in_valid = 1'b0;
  logic [6:0] in_data = '0;
  logic       in_ready;
  logic [1:0] rf_raddr_a, rf_raddr_b, rf_waddr;
  logic [2:0] alu_op;
  logic       alu_en, rf_we, wb_sel, out_we, busy;
  logic [3:0] imm;
  logic [7:0] retired;

  femto_seq #(
    .OPSIZE (3),
    .NUMRF  (2),
    .SIZE   (4),
    .QDEPTH (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .rf_raddr_a (rf_raddr_a),
    .rf_raddr_b (rf_raddr_b),
    .alu_op     (alu_op),
    .alu_en     (alu_en),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .wb_sel     (wb_sel),
    .imm        (imm),
    .out_we     (out_we),
    .busy       (busy),
    .retired    (retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [1:0] a;
    logic [1:0] b;
  } alu_exp_t;

  typedef struct {
    logic       rf;
    logic       out;
    logic [1:0] waddr;
    logic       sel;
    logic [3:0] imm;
  } wb_exp_t;

  alu_exp_t aq[$];
  wb_exp_t  rq[$];

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // reference model state
  logic       pend_ldi = 1'b0;
  logic [1:0] pend_rd  = '0;
  logic [3:0] exp_imm  = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail(input string name);
    n_checks++;
    $display("FAIL %s", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Decode a word the way the sequencer should and queue the expected events.
  task automatic model_word(input logic [6:0] w);
    alu_exp_t a;
    wb_exp_t  r;
    if (pend_ldi) begin
      pend_ldi = 1'b0;
      exp_imm  = w[3:0];
      r.rf = 1'b1; r.out = 1'b0; r.waddr = pend_rd; r.sel = 1'b1; r.imm = exp_imm;
      rq.push_back(r);
    end else if (w[6:4] == 3'd0) begin
      pend_ldi = 1'b1;
      pend_rd  = w[3:2];
    end else begin
      a.op = w[6:4]; a.a = w[3:2]; a.b = w[1:0];
      aq.push_back(a);
      r.rf    = (w[6:4] != 3'd7);
      r.out   = (w[6:4] == 3'd7);
      r.waddr = w[3:2];
      r.sel   = 1'b0;
      r.imm   = exp_imm;
      rq.push_back(r);
    end
  endtask

  task automatic push(input logic [6:0] w, input bit model);
    int unsigned n = 0;
    in_valid = 1'b1;
    in_data  = w;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    if (!in_ready) fail("push_timeout");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (model) model_word(w);
  endtask

  task automatic wait_idle();
    int unsigned n = 0;
    while ((busy || rq.size() != 0 || aq.size() != 0) && n < 400) begin
      tick();
      n++;
    end
    if (busy || rq.size() != 0 || aq.size() != 0) fail("idle_timeout");
  endtask

  // Monitor: compare every pulse against the scoreboard queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (alu_en || rf_we || out_we)
        check("pulse_exclusive", 32'(alu_en) + 32'(rf_we) + 32'(out_we), 1);
      if (alu_en) begin
        if (aq.size() == 0) fail("unexpected_alu_en");
        else begin
          alu_exp_t a;
          a = aq.pop_front();
          check("alu_op", alu_op, a.op);
          check("alu_raddr", {rf_raddr_a, rf_raddr_b}, {a.a, a.b});
        end
      end
      if (rf_we || out_we) begin
        if (rq.size() == 0) fail("unexpected_writeback");
        else begin
          wb_exp_t r;
          r = rq.pop_front();
          check("wb_kind", {rf_we, out_we}, {r.rf, r.out});
          check("wb_waddr", rf_waddr, r.waddr);
          check("wb_sel", wb_sel, r.sel);
          check("wb_imm", imm, r.imm);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    tick(); tick();
    check("rst_outputs", {rf_raddr_a, rf_raddr_b, alu_op, alu_en, rf_we, rf_waddr,
                          wb_sel, imm, out_we, busy, retired}, 0);
    check("rst_in_ready", in_ready, 1);
    rst = 1'b0;
    tick();

    // Fill the FIFO with run low; a fifth word must be refused.
    push(7'h16, 1);
    push(7'h17, 1);
    push(7'h15, 1);
    check("ready_before_full", in_ready, 1);
    push(7'h14, 1);
    check("ready_when_full", in_ready, 0);
    in_valid = 1'b1;
    in_data  = 7'h1F;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("full_holds", {in_ready, busy}, 2'b00);
    end
    in_valid = 1'b0;
    run = 1'b1;
    wait_idle();
    check("retired_after_fill", retired, 4);

    // Asynchronous reset mid-instruction, away from any clock edge
    push(7'h16, 0);
    tick();
    check("partial_in_read", {busy, rf_raddr_a, rf_raddr_b}, {1'b1, 2'd1, 2'd2});
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_outputs", {rf_raddr_a, rf_raddr_b, alu_op, alu_en, rf_we, rf_waddr,
                                wb_sel, imm, out_we, busy, retired}, 0);
    check("async_rst_in_ready", in_ready, 1);
    run = 1'b0;
    exp_imm = '0;
    tick(); tick();
    rst = 1'b0;
    run = 1'b1;
    tick();

    // LDI r3, 5
    push(7'h0C, 1);
    push(7'h05, 1);
    wait_idle();
    check("ldi_retired", retired, 1);
    check("ldi_imm", imm, 5);

    // ADD r1, r2: directed cycle timing
    push(7'h16, 1);
    check("add_idle", busy, 0);
    tick();
    check("add_read", {busy, rf_raddr_a, rf_raddr_b, alu_en}, {1'b1, 2'd1, 2'd2, 1'b0});
    tick();
    check("add_exec", {alu_en, alu_op, rf_we}, {1'b1, 3'd1, 1'b0});
    tick();
    check("add_wb", {rf_we, wb_sel, alu_en}, {1'b1, 1'b0, 1'b0});
    tick();
    check("add_done", {busy, retired}, {1'b0, 8'd2});

    // LDI starvation: IMM waits for the immediate, run ignored
    push(7'h00, 1);
    tick();
    run = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("imm_wait", {busy, alu_en, rf_we, out_we}, 4'b1000);
      tick();
    end
    push(7'h0A, 1);
    check("imm_still_waiting", {busy, rf_we}, 2'b10);
    tick();
    check("imm_wb", {rf_we, wb_sel, imm, rf_waddr}, {1'b1, 1'b1, 4'hA, 2'd0});
    tick();
    check("imm_done", {busy, retired}, {1'b0, 8'd3});
    run = 1'b1;

    // OUT, with run dropped during its EXEC
    push(7'h70, 1);
    push(7'h16, 1);
    tick();
    check("out_exec", {alu_en, alu_op}, {1'b1, 3'd7});
    run = 1'b0;
    tick();
    check("out_wb", {out_we, rf_we}, 2'b10);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("held_idle", {busy, in_ready, alu_en, rf_we}, 4'b0100);
      tick();
    end
    check("retired_before_resume", retired, 4);
    run = 1'b1;
    wait_idle();
    check("retired_after_resume", retired, 5);

    // Wrap: 251 more ALU instructions bring the total to 256
    for (int i = 0; i < 251; i++) begin
      logic [6:0] w;
      w[6:4] = 3'(1 + (i % 6));
      w[3:2] = 2'(i % 4);
      w[1:0] = 2'((i / 4) % 4);
      push(w, 1);
    end
    wait_idle();
    check("retired_wrap", retired, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/femto_seq.md
# femto_seq

Instruction sequencer for the femto core. Accepts instruction words over a valid/ready port and buffers them in a small FIFO. Runs a fixed multi-cycle FSM that drives the register-file addresses, the ALU opcode/enable, the write-back controls and the output-latch enable of the femto datapath. Sits between the chip-level pin mapping and the datapath (register file + ALU + output latch) inside the core top level.

## Interface
Parameters:
- OPSIZE, 3, opcode width; 2**OPSIZE opcodes
- NUMRF, 2, register-address width; 2**NUMRF registers
- SIZE, 4, data width; must satisfy SIZE <= OPSIZE+2*NUMRF
- QDEPTH, 2, FIFO depth is 2**QDEPTH words

Derived: IW = OPSIZE+2*NUMRF (7 at defaults). Word layout: op = [IW-1 -: OPSIZE], rd = next NUMRF bits, rs = low NUMRF bits.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- run  in  1  1 = FSM may leave IDLE; 0 = load-only
- in_valid  in  1  instruction word offered
- in_data  in  IW  instruction or immediate word
- in_ready  out  1  = !fifo_full
- rf_raddr_a  out  NUMRF  = IR.rd (registered, from IR)
- rf_raddr_b  out  NUMRF  = IR.rs
- alu_op  out  OPSIZE  = IR.op
- alu_en  out  1  one-cycle pulse in EXEC
- rf_we  out  1  one-cycle pulse in WB (not for OUT)
- rf_waddr  out  NUMRF  = IR.rd
- wb_sel  out  1  1 = write imm, 0 = write ALU result
- imm  out  SIZE  immediate register
- out_we  out  1  one-cycle pulse in WB for OUT
- busy  out  1  state != IDLE
- retired  out  8  instructions completed, wraps 255->0

Reset value of every output: 0, except in_ready, which is 1 because the FIFO is empty.

## Operation
- Opcodes: 0 LDI, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 MOV, 7 OUT. Opcodes 1-6 are ALU ops and are not interpreted here.
- LDI is two words: an instruction word, then an immediate word. imm takes the low SIZE bits of the immediate word.
- FIFO push when in_valid && in_ready. Pop only under FSM command.
- No bypass. A word pushed at edge k is poppable at edge k+1 at the earliest.
- Simultaneous push and pop is legal when the FIFO is neither full nor empty.
- When full, in_ready=0 even if a pop occurs in the same cycle.
- FSM states: IDLE, IMM, READ, EXEC, WB.
  - IDLE: if run && !empty, pop into IR; go to IMM if op==LDI, else READ. Otherwise stay.
  - IMM: if !empty, pop into imm and go to WB. Otherwise stay; the FSM waits indefinitely and run is ignored.
  - READ: addresses are stable; go to EXEC.
  - EXEC: alu_en=1; go to WB.
  - WB:
    - LDI: rf_we=1, wb_sel=1.
    - ALU op: rf_we=1, wb_sel=0.
    - OUT: out_we=1, rf_we=0.
    - In all cases retired++ and go to IDLE.
- wb_sel is 1 exactly while IR.op==LDI; otherwise 0.
- Dropping run mid-instruction does not abort it. The current instruction completes and the FSM then holds in IDLE.
- rst mid-operation clears the FIFO pointers, IR, imm, retired and the state immediately (async). A partially executed instruction is discarded with no rf_we or out_we.

## Timing
- Latency for a word already in the FIFO when in IDLE:
  - ALU/OUT: 4 cycles (IDLE, READ, EXEC, WB).
  - LDI: 3 cycles (IDLE, IMM, WB) if the immediate word is already queued.
- Back-to-back throughput: one ALU instruction per 4 clocks.
- alu_en, rf_we and out_we are each high for exactly one cycle per instruction and never overlap.
- rf_raddr_a/b are valid from the cycle after the IDLE pop until the next IDLE pop. The datapath samples the register file in READ.

## Structure
- Package femto_pkg holds:
  - opcode localparams (OP_LDI … OP_OUT)
  - state encoding (S_IDLE, S_IMM, S_READ, S_EXEC, S_WB)
  - the IW derivation
- Sub-module femto_ififo: parameterised synchronous FIFO (width IW, depth 2**QDEPTH).
  - Interface: push, pop, full, empty, head, using a count register.
- femto_seq instantiates femto_ififo and contains the FSM, IR, imm and the retired counter.

## Test plan
- Reset: assert rst asynchronously mid-cycle, with no clock edge. Required: all outputs 0 and in_ready=1 immediately. After release with run=0, push 4 words: in_ready falls after the 4th; a 5th word is not accepted.
- LDI: run=1; push 0x0C (LDI rd=3), then 0x05. Required: rf_we pulses once with rf_waddr=3, wb_sel=1, imm=5; alu_en is never asserted; retired=1.
- ADD: push 0x16 (ADD rd=1, rs=2). Required:
  - rf_raddr_a=1 and rf_raddr_b=2 in READ.
  - alu_en one cycle later with alu_op=1.
  - rf_we the following cycle with wb_sel=0.
  - total 4 cycles from IDLE.
- LDI starvation: push 0x00 alone. Required: FSM holds in IMM with busy=1 and no pulses for 10 cycles. Then push 0x0A: WB follows one cycle after the pop with imm=0xA.
- OUT, run drop, wrap: push 0x70 (OUT rs=0), then 0x16, and drop run during the OUT's EXEC. Required: out_we=1 and rf_we=0 in WB; 0x16 stays queued until run returns. Separately, retire 256 instructions: retired wraps to 0.
